// File: rtl/ahb_pkg.sv
// Shared AHB-Lite codes, slave FSM states and transfer decode helpers
// for the SRAM slave.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'd0;
    localparam logic [1:0] HTRANS_BUSY   = 2'd1;
    localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
    localparam logic [1:0] HTRANS_SEQ    = 2'd3;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR1 = 2'd2,
        ST_ERR2 = 2'd3
    } state_e;

    // Little-endian lane enables; unsupported sizes enable nothing.
    function automatic logic [3:0] byte_en(input logic [2:0] size, input logic [1:0] lane);
        case (size)
            HSIZE_BYTE: return 4'b0001 << lane;
            HSIZE_HALF: return lane[1] ? 4'b1100 : 4'b0011;
            HSIZE_WORD: return 4'b1111;
            default:    return 4'b0000;
        endcase
    endfunction

    function automatic logic misaligned(input logic [2:0] size, input logic [1:0] lane);
        case (size)
            HSIZE_HALF: return lane[0];
            HSIZE_WORD: return lane != 2'b00;
            default:    return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ahb_sram_array.sv
// Word-organised register-file storage: four byte lanes with per-lane
// synchronous write enables, combinational read. Contents are not reset.
module ahb_sram_array #(
    parameter int AW = 10
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [3:0]    be_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [31:0]   wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [31:0]   rdata_o
);

    logic [3:0][7:0] mem_q [2**AW];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int l = 0; l < 4; l++) begin
                if (be_i[l]) mem_q[waddr_i][l] <= wdata_i[8*l +: 8];
            end
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave with two-cycle ERROR response for bad transfers.
// Define AHB_SRAM_WAIT_EN to compile in the programmable wait-state counter.
module ahb_sram_slave
    import ahb_pkg::*;
#(
    parameter int          ADDR_W      = 12,
    parameter int          WAIT_STATES = 0,
    parameter int unsigned BASE_LIMIT  = 2**ADDR_W
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        HSEL,
    input  logic        HREADYIN,
    input  logic [1:0]  HTRANS,
    input  logic [2:0]  HSIZE,
    input  logic        HWRITE,
    input  logic [31:0] HADDR,
    input  logic [31:0] HWDATA,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic [31:0] HRDATA
);

    localparam int WA_W = ADDR_W - 2;

    state_e state_q, state_d;

    logic              dp_vld_q,   dp_vld_d;
    logic [ADDR_W-1:0] dp_addr_q,  dp_addr_d;
    logic [2:0]        dp_size_q,  dp_size_d;
    logic              dp_write_q, dp_write_d;
    logic              dp_err_q,   dp_err_d;

    logic        hready;
    logic        accept;
    logic        err_new;
    logic        mem_we;
    logic [31:0] mem_rdata;
    logic [31:0] addr_ext;
    state_e      start_state;

    logic unused_haddr;
    assign unused_haddr = ^HADDR[31:ADDR_W];

`ifdef AHB_SRAM_WAIT_EN
    localparam bit USE_WAIT = (WAIT_STATES != 0);

    logic [3:0] cnt_q, cnt_d;

    // Counter reloads on every accepted transfer and only counts down in WAIT.
    always_comb begin
        cnt_d = cnt_q;
        if (accept)
            cnt_d = 4'(WAIT_STATES);
        else if (state_q == ST_WAIT && cnt_q != 4'd0)
            cnt_d = cnt_q - 4'd1;
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) cnt_q <= 4'd0;
        else        cnt_q <= cnt_d;
    end
`else
    localparam bit USE_WAIT = 1'b0;

    logic [3:0] unused_ws;
    assign unused_ws = 4'(WAIT_STATES);
`endif

    assign accept   = HSEL && HREADYIN && hready &&
                      (HTRANS == HTRANS_NONSEQ || HTRANS == HTRANS_SEQ);
    assign addr_ext = 32'(HADDR[ADDR_W-1:0]);
    assign err_new  = (HSIZE > HSIZE_WORD) || (addr_ext >= BASE_LIMIT) ||
                      misaligned(HSIZE, HADDR[1:0]);

    assign start_state = err_new  ? ST_ERR1 :
                         USE_WAIT ? ST_WAIT : ST_IDLE;

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q    <= ST_IDLE;
            dp_vld_q   <= 1'b0;
            dp_addr_q  <= '0;
            dp_size_q  <= 3'd0;
            dp_write_q <= 1'b0;
            dp_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            dp_vld_q   <= dp_vld_d;
            dp_addr_q  <= dp_addr_d;
            dp_size_q  <= dp_size_d;
            dp_write_q <= dp_write_d;
            dp_err_q   <= dp_err_d;
        end
    end

    // The data-phase register only moves when the current phase completes.
    always_comb begin
        state_d    = state_q;
        dp_vld_d   = dp_vld_q;
        dp_addr_d  = dp_addr_q;
        dp_size_d  = dp_size_q;
        dp_write_d = dp_write_q;
        dp_err_d   = dp_err_q;

        case (state_q)
            ST_IDLE, ST_ERR2: state_d = accept ? start_state : ST_IDLE;
            ST_WAIT: begin
`ifdef AHB_SRAM_WAIT_EN
                state_d = (cnt_q > 4'd1) ? ST_WAIT : ST_IDLE;
`else
                state_d = ST_IDLE;
`endif
            end
            ST_ERR1: state_d = ST_ERR2;
            default: state_d = ST_IDLE;
        endcase

        if (hready) begin
            dp_vld_d   = accept;
            dp_addr_d  = accept ? HADDR[ADDR_W-1:0] : '0;
            dp_size_d  = accept ? HSIZE : 3'd0;
            dp_write_d = accept && HWRITE;
            dp_err_d   = accept && err_new;
        end
    end

    always_comb begin
        hready    = (state_q != ST_WAIT) && (state_q != ST_ERR1);
        HREADYOUT = hready;
        HRESP     = (state_q == ST_ERR1 || state_q == ST_ERR2) ? HRESP_ERROR : HRESP_OKAY;
        // Any OKAY phase still pending while ready is high is completing now.
        mem_we    = hready && dp_vld_q && !dp_err_q && dp_write_q;
        HRDATA    = (dp_vld_q && !dp_err_q && !dp_write_q) ? mem_rdata : 32'd0;
    end

    ahb_sram_array #(
        .AW(WA_W)
    ) u_array (
        .clk_i   (HCLK),
        .we_i    (mem_we),
        .be_i    (byte_en(dp_size_q, dp_addr_q[1:0])),
        .waddr_i (dp_addr_q[ADDR_W-1:2]),
        .wdata_i (HWDATA),
        .raddr_i (dp_addr_q[ADDR_W-1:2]),
        .rdata_o (mem_rdata)
    );

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Directed bench: u0 is zero-wait with a lowered BASE_LIMIT, u3 has three
// wait states (zero when AHB_SRAM_WAIT_EN is undefined).
module tb_ahb_sram_slave;

`ifdef AHB_SRAM_WAIT_EN
    localparam int EW3 = 3;
`else
    localparam int EW3 = 0;
`endif

    typedef struct packed {
        logic        d3;
        logic        wr;
        logic [2:0]  sz;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] rd;
        logic        err;
    } vec_t;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic        hsel0, hsel3, cur3;
    logic        hreadyin;
    logic [1:0]  htrans;
    logic [2:0]  hsize;
    logic        hwrite;
    logic [31:0] haddr, hwdata;
    logic        ro0, ro3, resp0, resp3;
    logic [31:0] rd0, rd3;

    int total = 0;
    int bad   = 0;

    always #5 HCLK = ~HCLK;

    assign hreadyin = cur3 ? ro3 : ro0;

    ahb_sram_slave #(.ADDR_W(12), .WAIT_STATES(0), .BASE_LIMIT(32'h800)) u0 (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(hsel0), .HREADYIN(hreadyin),
        .HTRANS(htrans), .HSIZE(hsize), .HWRITE(hwrite), .HADDR(haddr),
        .HWDATA(hwdata), .HREADYOUT(ro0), .HRESP(resp0), .HRDATA(rd0)
    );

    ahb_sram_slave #(.ADDR_W(12), .WAIT_STATES(3)) u3 (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(hsel3), .HREADYIN(hreadyin),
        .HTRANS(htrans), .HSIZE(hsize), .HWRITE(hwrite), .HADDR(haddr),
        .HWDATA(hwdata), .HREADYOUT(ro3), .HRESP(resp3), .HRDATA(rd3)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    // One non-pipelined transfer; returns wait count and completion-cycle outputs.
    task automatic xfer(input logic d3, input logic wr, input logic [2:0] sz,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output int waits,
                        output logic resp_first, output logic resp_end);
        cur3   = d3;
        hsel0  = !d3;
        hsel3  = d3;
        htrans = 2'd2;
        hwrite = wr;
        hsize  = sz;
        haddr  = a;
        tick();
        hsel0  = 1'b0;
        hsel3  = 1'b0;
        htrans = 2'd0;
        hwdata = wd;
        waits  = 0;
        resp_first = d3 ? resp3 : resp0;
        while ((d3 ? ro3 : ro0) == 1'b0 && waits < 20) begin
            waits++;
            tick();
        end
        rd       = d3 ? rd3 : rd0;
        resp_end = d3 ? resp3 : resp0;
        tick();
    endtask

    function automatic vec_t mk(input logic d3, input logic wr, input logic [2:0] sz,
                                input logic [31:0] a, input logic [31:0] wd,
                                input logic [31:0] rd, input logic err);
        vec_t v;
        v.d3 = d3; v.wr = wr; v.sz = sz; v.a = a; v.wd = wd; v.rd = rd; v.err = err;
        return v;
    endfunction

    initial begin
        vec_t        vecs[$];
        logic [31:0] rd;
        int          waits;
        logic        rf, re;

        vecs.push_back(mk(0, 0, 3'd2, 32'h0000_1010, 32'h0,          32'hDEADBEEF, 0));
        vecs.push_back(mk(0, 1, 3'd2, 32'h0000_0040, 32'h11223344,   32'h0,        0));
        vecs.push_back(mk(0, 1, 3'd0, 32'h0000_0043, 32'hAA000000,   32'h0,        0));
        vecs.push_back(mk(0, 0, 3'd2, 32'h0000_0040, 32'h0,          32'hAA223344, 0));
        vecs.push_back(mk(0, 1, 3'd1, 32'h0000_0042, 32'h55660000,   32'h0,        0));
        vecs.push_back(mk(0, 0, 3'd2, 32'h0000_0040, 32'h0,          32'h55663344, 0));
        vecs.push_back(mk(0, 1, 3'd2, 32'h0000_0048, 32'h00000000,   32'h0,        0));
        vecs.push_back(mk(0, 1, 3'd0, 32'h0000_0049, 32'h0000BB00,   32'h0,        0));
        vecs.push_back(mk(0, 1, 3'd0, 32'h0000_004A, 32'h00CC0000,   32'h0,        0));
        vecs.push_back(mk(0, 0, 3'd2, 32'h0000_0048, 32'h0,          32'h00CCBB00, 0));
        vecs.push_back(mk(0, 1, 3'd1, 32'h0000_0048, 32'h00007788,   32'h0,        0));
        vecs.push_back(mk(0, 0, 3'd2, 32'h0000_0048, 32'h0,          32'h00CC7788, 0));
        vecs.push_back(mk(0, 1, 3'd2, 32'h0000_07FC, 32'h0BADF00D,   32'h0,        0));
        vecs.push_back(mk(0, 0, 3'd2, 32'h0000_07FC, 32'h0,          32'h0BADF00D, 0));
        vecs.push_back(mk(0, 1, 3'd2, 32'h0000_0800, 32'h12345678,   32'h0,        1));
        vecs.push_back(mk(0, 0, 3'd2, 32'h0000_0800, 32'h0,          32'h0,        1));
        vecs.push_back(mk(0, 1, 3'd1, 32'h0000_0041, 32'hFFFFFFFF,   32'h0,        1));
        vecs.push_back(mk(0, 1, 3'd3, 32'h0000_0040, 32'hFFFFFFFF,   32'h0,        1));
        vecs.push_back(mk(0, 1, 3'd2, 32'h0000_0042, 32'hFFFFFFFF,   32'h0,        1));
        vecs.push_back(mk(0, 0, 3'd2, 32'h0000_0040, 32'h0,          32'h55663344, 0));
        vecs.push_back(mk(1, 1, 3'd2, 32'h0000_0020, 32'hCAFEF00D,   32'h0,        0));
        vecs.push_back(mk(1, 0, 3'd2, 32'h0000_0020, 32'h0,          32'hCAFEF00D, 0));
        vecs.push_back(mk(1, 1, 3'd0, 32'h0000_0021, 32'h00001100,   32'h0,        0));
        vecs.push_back(mk(1, 1, 3'd1, 32'h0000_0023, 32'hFFFFFFFF,   32'h0,        1));
        vecs.push_back(mk(1, 0, 3'd2, 32'h0000_0020, 32'h0,          32'hCAFE110D, 0));

        HRESET = 1'b1;
        cur3 = 1'b0; hsel0 = 1'b0; hsel3 = 1'b0;
        htrans = 2'd0; hsize = 3'd2; hwrite = 1'b0; haddr = '0; hwdata = '0;
        tick();
        tick();
        chk("reset_ready0", 32'(ro0),  32'd1);
        chk("reset_resp0",  32'(resp0), 32'd0);
        chk("reset_rdata0", rd0,        32'd0);
        chk("reset_ready3", 32'(ro3),  32'd1);
        chk("reset_resp3",  32'(resp3), 32'd0);
        chk("reset_rdata3", rd3,        32'd0);
        HRESET = 1'b0;
        tick();

        // Back-to-back write then read on the zero-wait slave.
        cur3 = 1'b0; hsel0 = 1'b1; htrans = 2'd2; hwrite = 1'b1; hsize = 3'd2; haddr = 32'h10;
        tick();
        chk("b2b_wr_ready", 32'(ro0), 32'd1);
        hwdata = 32'hDEADBEEF; hwrite = 1'b0;
        tick();
        chk("b2b_rd_ready", 32'(ro0),  32'd1);
        chk("b2b_rd_resp",  32'(resp0), 32'd0);
        chk("b2b_rd_data",  rd0,        32'hDEADBEEF);
        hsel0 = 1'b0; htrans = 2'd0;
        tick();
        chk("b2b_idle_data", rd0, 32'd0);

        // BUSY and IDLE are not accepted: zero-wait OKAY, nothing written.
        hsel0 = 1'b1; htrans = 2'd1; hwrite = 1'b1; haddr = 32'h10; hwdata = 32'h0;
        tick();
        chk("busy_ready", 32'(ro0),  32'd1);
        chk("busy_resp",  32'(resp0), 32'd0);
        chk("busy_rdata", rd0,        32'd0);
        htrans = 2'd0;
        tick();
        chk("idle_ready", 32'(ro0), 32'd1);
        hsel0 = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            int exp_w;
            exp_w = vecs[i].err ? 1 : (vecs[i].d3 ? EW3 : 0);
            xfer(vecs[i].d3, vecs[i].wr, vecs[i].sz, vecs[i].a, vecs[i].wd, rd, waits, rf, re);
            chk($sformatf("vec%0d_waits", i),     32'(waits), 32'(exp_w));
            chk($sformatf("vec%0d_resp_first", i), 32'(rf),   32'(vecs[i].err));
            chk($sformatf("vec%0d_resp_end", i),   32'(re),   32'(vecs[i].err));
            chk($sformatf("vec%0d_rdata", i), rd,
                (!vecs[i].wr && !vecs[i].err) ? vecs[i].rd : 32'd0);
        end

        // Reset in the middle of a waited write data phase aborts the write.
        xfer(1, 1, 3'd2, 32'h30, 32'h11111111, rd, waits, rf, re);
        chk("rst_pre_waits", 32'(waits), 32'(EW3));
        cur3 = 1'b1; hsel3 = 1'b1; htrans = 2'd2; hwrite = 1'b1; hsize = 3'd2; haddr = 32'h30;
        tick();
        hsel3 = 1'b0; htrans = 2'd0; hwdata = 32'h22222222;
        HRESET = 1'b1;
        #1;
        chk("rst_mid_ready", 32'(ro3),  32'd1);
        chk("rst_mid_resp",  32'(resp3), 32'd0);
        tick();
        HRESET = 1'b0;
        tick();
        xfer(1, 0, 3'd2, 32'h30, 32'h0, rd, waits, rf, re);
        chk("rst_post_waits", 32'(waits), 32'(EW3));
        chk("rst_post_resp",  32'(re),    32'd0);
        chk("rst_post_data",  rd,         32'h11111111);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ahb_sram_slave.md
# ahb_sram_slave

AHB-Lite slave memory that answers the DMA controller's AHB master port: it decodes one transfer per address phase, accepts write data or returns read data in the following data phase, and inserts programmable wait states. It sits on the system bus as the source/destination memory for DMA channel traffic and for the bench that exercises the DMA engine. Out-of-range or unsupported transfers get the standard two-cycle ERROR response.

## Interface
Parameters:
- ADDR_W, 12: byte-address bits decoded; depth = 2^(ADDR_W-2) words.
- WAIT_STATES, 0: wait cycles inserted in every OKAY data phase, 0..15.
- BASE_LIMIT, 2^ADDR_W: byte addresses at or above this get an ERROR response.

Ports:
- HCLK  in  1  bus clock, all logic on rising edge.
- HRESET  in  1  asynchronous, active-high reset.
- HSEL  in  1  slave select.
- HREADYIN  in  1  bus ready; an address phase is sampled only when HSEL & HREADYIN & HTRANS[1].
- HTRANS  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- HSIZE  in  3  0=byte, 1=half, 2=word; larger values are errors.
- HWRITE  in  1  1=write.
- HADDR  in  32  byte address; bits [ADDR_W-1:0] are decoded, upper bits are ignored.
- HWDATA  in  32  write data, valid in the data phase.
- HREADYOUT  out  1  data phase complete.
- HRESP  out  1  0=OKAY, 1=ERROR.
- HRDATA  out  32  read data, valid when HREADYOUT=1 in a read data phase.

## Operation
- State machine states:
  - IDLE: no pending data phase.
  - WAIT: counting wait states.
  - ERR1, ERR2: the two cycles of the error response.
- Address phase accept: when a transfer is sampled, register addr, size, write and an error flag into the data-phase register.
  - error flag = (HSIZE>2) | (addr[ADDR_W-1:0] >= BASE_LIMIT) | misalignment. Misaligned means half with addr[0]=1, or word with addr[1:0]!=0.
- Transitions:
  - IDLE goes to WAIT on an accepted OKAY transfer with WAIT_STATES>0, and to ERR1 on an accepted erroring transfer.
  - With WAIT_STATES=0, an accepted OKAY transfer completes in the next cycle and the block stays in IDLE.
  - WAIT counts WAIT_STATES cycles, then the data phase completes.
  - ERR1 goes to ERR2, and ERR2 goes to IDLE.
  - If a new transfer is accepted on the completing cycle, its data phase starts immediately (back-to-back), following the same rules.
- Writes:
  - Committed on the rising edge that ends an OKAY data phase (HREADYOUT=1).
  - Byte enables come from size and addr[1:0], little-endian lanes. A half-word at addr[1]=1 writes lanes 3:2.
- Reads:
  - Combinational from the array at the registered word address; full word returned on HRDATA, lane selection is the master's job.
  - HRDATA is 0 outside read data phases.
  - A read directly after a write to the same word returns the new data, because the write commits before the read's data phase.
- BUSY/IDLE transfers are not accepted and give a zero-wait OKAY.
- An erroring write never modifies memory.

## Timing
- Reset values: HREADYOUT=1, HRESP=0, HRDATA=0, state=IDLE, wait counter=0, data-phase register cleared. Memory contents are not reset.
- Zero-wait OKAY: the data phase completes in the cycle after the address phase.
- N wait states: HREADYOUT=0 for N cycles, then 1.
- ERROR, ERR1: HREADYOUT=0, HRESP=1.
- ERROR, ERR2: HREADYOUT=1, HRESP=1.
- The wait counter is 4 bits and reloads on every accepted transfer; it never wraps.
- Reset asserted mid data phase aborts the transfer; a pending write is not committed.

## Configuration
- AHB_SRAM_WAIT_EN defined: the WAIT state and counter are compiled in and the WAIT_STATES parameter applies.
- AHB_SRAM_WAIT_EN undefined: no counter and no WAIT state. Every OKAY transfer is zero-wait and WAIT_STATES is ignored.

## Structure
- Shared package ahb_pkg holds:
  - HTRANS codes;
  - HSIZE codes;
  - HRESP codes;
  - the state enum (IDLE/WAIT/ERR1/ERR2).
- Sub-module ahb_sram_array: register-file storage with 4-lane byte-enable synchronous write and combinational read. The AHB control logic stays in the top module.

## Test plan
- Reset with HRESET=1 -> HREADYOUT=1, HRESP=0, HRDATA=0.
- WAIT_STATES=0: word write 0xDEADBEEF to 0x010, then read 0x010 back-to-back -> read returns 0xDEADBEEF with HREADYOUT high in every cycle.
- WAIT_STATES=3: read 0x020 -> HREADYOUT low for exactly 3 cycles, then data is valid.
- Byte write 0xAA to 0x043 over word 0x11223344 -> read 0x040 returns 0xAA223344. Half write 0x5566 to 0x042 -> read returns 0x55663344.
- Write to BASE_LIMIT, half at 0x001, and HSIZE=3 -> each gives the ERR1/ERR2 sequence (HREADYOUT 0 then 1, HRESP=1), and memory is unchanged.
- Reset pulse during a 3-wait write data phase -> the target word keeps its old value, and the next transfer behaves normally.
